temp_frame_assembler: RTL

TEMP_FRAME_ASSEMBLER -- requirements
Module: temp_frame_assembler

---
 rtl/temp_frame_assembler_pkg.sv | 24 ++
 rtl/temp_frame_assembler_avg4.sv | 47 ++++
 rtl/temp_frame_assembler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/temp_frame_assembler_pkg.sv
// Shared types and constants for the temperature frame assembler.
// Holds the sample width, frame layout, alarm thresholds, timeout and read FSM encoding.
package temp_pkg;

    localparam int              TEMP_W    = 13;
    localparam int              FRAME_LEN = 4;
    localparam logic [7:0]      PAD_BYTE  = 8'h00;
    localparam logic [TEMP_W-1:0] THRESH_HI = 13'd1400;
    localparam logic [TEMP_W-1:0] THRESH_LO = 13'd1300;
    localparam logic [15:0]     TIMEOUT   = 16'd4000;

    typedef enum logic {
        S_REQ = 1'b0,
        S_CAP = 1'b1
    } rd_state_e;

    // Hysteresis: set at or above HI, clear at or below LO, otherwise hold.
    function automatic logic alarm_next(input logic [TEMP_W-1:0] avg, input logic cur);
        if (avg >= THRESH_HI) return 1'b1;
        if (avg <= THRESH_LO) return 1'b0;
        return cur;
    endfunction

endpackage

// File: rtl/temp_frame_assembler_avg4.sv
// Four-entry sample history with first-sample fill and truncating average.
// o_avg_next is the average that a load in this cycle will produce.
module temp_avg4
    import temp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [TEMP_W-1:0] i_sample,
    output logic [TEMP_W-1:0] o_avg,
    output logic [TEMP_W-1:0] o_avg_next
);

    logic [TEMP_W-1:0] r_hist [0:3];
    logic [TEMP_W-1:0] r_avg;
    logic              r_first;
    logic [TEMP_W+1:0] w_sum;

    // The oldest entry is shifted out by this load, so it is not part of the new sum.
    always_comb begin
        w_sum      = {2'b00, i_sample} + {2'b00, r_hist[0]} +
                     {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
        o_avg_next = r_first ? i_sample : w_sum[TEMP_W+1:2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= 1'b1;
            r_avg   <= '0;
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
        end else if (i_load) begin
            if (r_first) begin
                for (int i = 0; i < 4; i++) r_hist[i] <= i_sample;
            end else begin
                r_hist[0] <= i_sample;
                r_hist[1] <= r_hist[0];
                r_hist[2] <= r_hist[1];
                r_hist[3] <= r_hist[2];
            end
            r_first <= 1'b0;
            r_avg   <= o_avg_next;
        end
    end

    assign o_avg = r_avg;

endmodule

// File: rtl/temp_frame_assembler.sv
// Pulls 4-byte temperature frames from a byte FIFO, validates padding and idle timeout,
// and publishes the raw sample, a 4-sample average and a hysteretic over-temperature alarm.
module temp_frame_assembler
    import temp_pkg::*;
(
    input  logic              clk_fix,
    input  logic              rst_fix_n,
    input  logic              fifo_temp_empty,
    output logic              fifo_temp_rd_en,
    input  logic [7:0]        fifo_temp_dout,
    output logic [TEMP_W-1:0] temp_raw,
    output logic [TEMP_W-1:0] temp_avg,
    output logic              temp_valid,
    output logic              frame_err,
    output logic              temp_alarm,
    output rd_state_e         o_dbg_state
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    rd_state_e         r_state, w_state_next;
    logic [1:0]        r_idx;
    logic [15:0]       r_to_cnt;
    logic [7:0]        r_b0;
    logic [4:0]        r_b1_hi;
    logic [7:0]        r_p0;
    logic [TEMP_W-1:0] r_raw;
    logic              r_valid, r_err, r_alarm;

    logic              w_rd_en, w_cap, w_last, w_pad_ok, w_good, w_bad, w_idle, w_timeout;
    logic [TEMP_W-1:0] w_sample, w_avg, w_avg_next;

    // Reads are only issued from S_REQ, so at most one byte is ever in flight.
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            S_REQ: begin
                if (!fifo_temp_empty) begin
                    w_rd_en      = rst_fix_n;
                    w_state_next = S_CAP;
                end
            end
            S_CAP:   w_state_next = S_REQ;
            default: w_state_next = S_REQ;
        endcase
    end

    always_comb begin
        w_cap     = (r_state == S_CAP);
        w_last    = w_cap && (r_idx == LAST_IDX);
        w_pad_ok  = (r_p0 == PAD_BYTE) && (fifo_temp_dout == PAD_BYTE);
        w_good    = w_last && w_pad_ok;
        w_bad     = w_last && !w_pad_ok;
        w_idle    = (r_idx != 2'd0) && !w_rd_en;
        w_timeout = w_idle && (r_to_cnt == TIMEOUT - 16'd1);
        w_sample  = {r_b0, r_b1_hi};
    end

    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The byte slot index wraps 3->0 on every final capture, good or bad.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_idx    <= 2'd0;
            r_to_cnt <= 16'd0;
            r_b0     <= 8'h00;
            r_b1_hi  <= 5'd0;
            r_p0     <= 8'h00;
        end else begin
            if (w_timeout) begin
                r_idx <= 2'd0;
            end else if (w_cap) begin
                r_idx <= r_idx + 2'd1;
                case (r_idx)
                    2'd0:    r_b0    <= fifo_temp_dout;
                    2'd1:    r_b1_hi <= fifo_temp_dout[7:3];
                    2'd2:    r_p0    <= fifo_temp_dout;
                    default: ;
                endcase
            end
            if (w_rd_en || (r_idx == 2'd0) || w_timeout) begin
                r_to_cnt <= 16'd0;
            end else begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_raw   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_valid <= w_good;
            r_err   <= w_bad || w_timeout;
            if (w_good) begin
                r_raw   <= w_sample;
                r_alarm <= alarm_next(w_avg_next, r_alarm);
            end
        end
    end

    temp_avg4 u_avg4 (
        .clk        (clk_fix),
        .rst_n      (rst_fix_n),
        .i_load     (w_good),
        .i_sample   (w_sample),
        .o_avg      (w_avg),
        .o_avg_next (w_avg_next)
    );

    assign fifo_temp_rd_en = w_rd_en;
    assign temp_raw        = r_raw;
    assign temp_avg        = w_avg;
    assign temp_valid      = r_valid;
    assign frame_err       = r_err;
    assign temp_alarm      = r_alarm;
    assign o_dbg_state     = r_state;

endmodule
